// File: rtl/mra_client_arbiter.sv
// -----------------------------------------------------------------------------
// mra_client_arbiter
//
// Shares the single L1-to-MRA request channel between N_CLIENTS requesters
// (0 = I-cache L1, 1 = D-cache L1, 2 = Tile Control FSM) and steers MRA read
// responses back to the client that issued the read.
//
// Arbitration is round-robin starting after the last winner. A grant that is
// not accepted in the cycle it is offered is locked, so the payload on
// mra_req_* stays stable until the MRA takes it. An in-order ID FIFO records
// the issuing client of every accepted read; responses pop it in order.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cl_req_valid/ready/rw/addr/data
//                     per-client request channel (addr/data flattened,
//                     client i at [i*W +: W])
//   mra_req_valid/ready/rw/addr/data
//                     muxed request channel towards the MRA
//   mra_rsp_valid/data
//                     read response from the MRA
//   cl_rsp_valid      one-hot response valid to the owning client
//   cl_rsp_data       response data broadcast to every client
//   outstanding       number of reads awaiting a response
//   rsp_err           sticky: a response arrived with no read outstanding
// -----------------------------------------------------------------------------
module mra_client_arbiter #(
    parameter int N_CLIENTS       = 3,
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_CLIENTS-1:0]            cl_req_valid,
    output logic [N_CLIENTS-1:0]            cl_req_ready,
    input  logic [N_CLIENTS-1:0]            cl_req_rw,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0] cl_req_data,
    output logic                            mra_req_valid,
    input  logic                            mra_req_ready,
    output logic                            mra_req_rw,
    output logic [ADDR_WIDTH-1:0]           mra_req_addr,
    output logic [DATA_WIDTH-1:0]           mra_req_data,
    input  logic                            mra_rsp_valid,
    input  logic [DATA_WIDTH-1:0]           mra_rsp_data,
    output logic [N_CLIENTS-1:0]            cl_rsp_valid,
    output logic [DATA_WIDTH-1:0]           cl_rsp_data,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            rsp_err
);

    localparam int ID_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]  fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_err_q, rsp_err_d;

    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             gnt_rw;
    logic             blocked;
    logic             accept;
    logic             push;
    logic             pop;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_CLIENTS);
            if (!win_found && cl_req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // A locked grant ignores every other client until it is accepted.
    assign gnt_id = lock_q ? lock_id_q : win_id;

    always_comb begin
        gnt_valid    = 1'b0;
        gnt_rw       = 1'b0;
        mra_req_addr = '0;
        mra_req_data = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_valid    = cl_req_valid[i];
                gnt_rw       = cl_req_rw[i];
                mra_req_addr = cl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mra_req_data = cl_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only reads need a FIFO slot; the full test uses the registered count,
    // so a pop in the same cycle does not free the slot early.
    assign blocked       = gnt_valid && !gnt_rw && (count_q == CNT_W'(MAX_OUTSTANDING));
    assign mra_req_valid = rst_n && gnt_valid && !blocked;
    assign mra_req_rw    = gnt_rw;
    assign accept        = mra_req_valid && mra_req_ready;
    assign push          = accept && !gnt_rw;
    assign pop           = mra_rsp_valid && (count_q != '0);

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cl_req_ready[i] = rst_n && gnt_valid && (gnt_id == ID_W'(i))
                              && mra_req_ready && !blocked;
            cl_rsp_valid[i] = rst_n && pop && (fifo_q[rd_ptr_q] == ID_W'(i));
        end
    end

    assign cl_rsp_data = mra_rsp_data;
    assign outstanding = count_q;
    assign rsp_err     = rsp_err_q;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rsp_err_d = rsp_err_q;

        // Offered but not taken (backpressure or full FIFO): hold the grant.
        // A locked client that drops valid simply releases the lock.
        if (accept) begin
            rr_ptr_d = gnt_id;
            lock_d   = 1'b0;
        end else if (gnt_valid) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end else begin
            lock_d = 1'b0;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = gnt_id;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (mra_rsp_valid && (count_q == '0)) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= ID_W'(N_CLIENTS - 1);
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule
